// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: measures high time and rise-to-rise period of a PWM line,
// with a sticky timeout and the line level when edges stop.
module pwm_duty_decoder #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             meas_valid,
    output logic             timeout,
    output logic             static_level
);
    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
    localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);
    state_t           state;
    logic             s1, pwm_s, pwm_d, rise, fall, at_to;
    logic [CNT_W-1:0] cnt, hi_lat, cnt_inc;
    assign rise    = pwm_s & ~pwm_d;
    assign fall    = ~pwm_s & pwm_d;
    assign at_to   = cnt == TO;
    assign cnt_inc = at_to ? cnt : cnt + 1'b1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1           <= 1'b0;
            pwm_s        <= 1'b0;
            pwm_d        <= 1'b0;
            state        <= IDLE;
            cnt          <= '0;
            hi_lat       <= '0;
            high_cnt     <= '0;
            period_cnt   <= '0;
            meas_valid   <= 1'b0;
            timeout      <= 1'b0;
            static_level <= 1'b0;
        end else begin
            s1         <= pwm_in;
            pwm_s      <= s1;
            pwm_d      <= pwm_s;
            meas_valid <= 1'b0;
            if (!ena) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (rise) begin
                            cnt     <= CNT_W'(1);
                            state   <= HIGH;
                            timeout <= 1'b0;
                        end else begin
                            cnt <= cnt_inc;
                            // latch the level only once so it reflects the moment edges stopped
                            if (at_to && !timeout) begin
                                timeout      <= 1'b1;
                                static_level <= pwm_s;
                            end
                        end
                    end
                    HIGH: begin
                        if (fall) begin
                            hi_lat <= cnt;
                            cnt    <= cnt_inc;
                            state  <= LOW;
                        end else if (at_to) begin
                            timeout      <= 1'b1;
                            static_level <= 1'b1;
                            state        <= IDLE;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    LOW: begin
                        if (rise) begin
                            high_cnt   <= hi_lat;
                            period_cnt <= cnt;
                            meas_valid <= 1'b1;
                            cnt        <= CNT_W'(1);
                            state      <= HIGH;
                        end else if (at_to) begin
                            timeout      <= 1'b1;
                            static_level <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb_pwm_duty_decoder: directed PWM waveforms; a monitor checks each
// meas_valid against a queue of hand-computed measurements.
module tb_pwm_duty_decoder;
    logic        clk = 1'b0, rst = 1'b1, ena = 1'b0, pwm_in = 1'b0;
    logic [15:0] high_cnt, period_cnt;
    logic        meas_valid, timeout, static_level;
    typedef struct {int h; int p; int gap;} exp_t;
    exp_t q[$];
    int checks = 0, fails = 0, cyc = 0, last = 0;

    pwm_duty_decoder #(.CNT_W(16), .TIMEOUT(1000)) dut (
        .clk(clk), .rst(rst), .ena(ena), .pwm_in(pwm_in),
        .high_cnt(high_cnt), .period_cnt(period_cnt), .meas_valid(meas_valid),
        .timeout(timeout), .static_level(static_level)
    );

    always #5 clk = ~clk;

    task automatic check(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(int h, int p, int gap);
        exp_t e;
        e.h = h; e.p = p; e.gap = gap;
        q.push_back(e);
    endtask

    task automatic drive(int h, int l);
        pwm_in = 1'b1;
        repeat (h) @(negedge clk);
        pwm_in = 1'b0;
        repeat (l) @(negedge clk);
    endtask

    // n = posedges after the pwm_in change at which timeout must first read 1
    task automatic to_check(int n, int lvl);
        repeat (n - 1) @(posedge clk);
        #1 check("timeout_early", int'(timeout), 0);
        @(posedge clk);
        #1 check("timeout", int'(timeout), 1);
        check("static_level", int'(static_level), lvl);
        @(negedge clk);
    endtask

    task automatic check_zero(string tag);
        check({tag, "_high_cnt"}, int'(high_cnt), 0);
        check({tag, "_period_cnt"}, int'(period_cnt), 0);
        check({tag, "_meas_valid"}, int'(meas_valid), 0);
        check({tag, "_timeout"}, int'(timeout), 0);
        check({tag, "_static_level"}, int'(static_level), 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst && meas_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_valid: got high_cnt=%0d period_cnt=%0d, expected no pulse", high_cnt, period_cnt);
                end else begin
                    e = q.pop_front();
                    check("meas_high_cnt", int'(high_cnt), e.h);
                    check("meas_period_cnt", int'(period_cnt), e.p);
                    if (e.gap != 0) check("meas_gap", cyc - last, e.gap);
                end
                last = cyc;
            end
        end
    end

    initial begin : stim
        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        ena = 1'b1;
        repeat (5) @(negedge clk);
        // 64/256 then 200/256; last rise comes from the hold-high below
        push(64, 256, 0); push(64, 256, 256); push(64, 256, 256); push(64, 256, 256);
        push(200, 256, 256); push(200, 256, 256); push(200, 256, 256);
        repeat (4) drive(64, 192);
        pwm_in = 1'b1;
        repeat (200) @(negedge clk);
        check("held_high_cnt", int'(high_cnt), 64);
        check("held_period_cnt", int'(period_cnt), 256);
        pwm_in = 1'b0;
        repeat (56) @(negedge clk);
        repeat (2) drive(200, 56);
        // stuck high: timeout 1000 cycles after the rise is acted on
        pwm_in = 1'b1;
        to_check(1003, 1);
        pwm_in = 1'b0;
        repeat (10) @(negedge clk);
        push(10, 20, 0); push(10, 20, 20);
        pwm_in = 1'b1;
        repeat (10) @(negedge clk);
        check("timeout_cleared", int'(timeout), 0);
        pwm_in = 1'b0;
        repeat (10) @(negedge clk);
        drive(10, 10);
        pwm_in = 1'b1;
        repeat (10) @(negedge clk);
        // stuck low after a fall: cnt resumes at 11, reaches 1000 after 990 edges
        pwm_in = 1'b0;
        to_check(993, 0);
        // rise lands exactly on cnt==TIMEOUT: measurement, not timeout
        push(10, 1000, 0);
        drive(10, 990);
        pwm_in = 1'b1;
        repeat (20) @(negedge clk);
        check("boundary_no_timeout", int'(timeout), 0);
        ena = 1'b0;
        repeat (50) @(negedge clk);
        check("ena_hold_high_cnt", int'(high_cnt), 10);
        check("ena_hold_period_cnt", int'(period_cnt), 1000);
        ena = 1'b1;
        repeat (30) @(negedge clk);
        pwm_in = 1'b0;
        repeat (30) @(negedge clk);
        push(1, 4, 0); push(1, 4, 4); push(1, 4, 4);
        repeat (3) drive(1, 3);
        pwm_in = 1'b1;
        repeat (6) @(negedge clk);
        pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero("async_reset");
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        push(7, 10, 0); push(7, 10, 10);
        repeat (2) drive(7, 3);
        pwm_in = 1'b1;
        repeat (5) @(negedge clk);
        pwm_in = 1'b0;
        repeat (20) @(negedge clk);
        check("pending_measurements", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
